// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the weighted round-robin arbiter
package arb_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_WW = 4;
  localparam int MAX_N = 64;
  localparam int MAX_WW = 16;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    return (idx < n) ? MAX_N'(1) << idx : '0;
  endfunction
  function automatic logic [MAX_WW-1:0] clamp_weight(input logic [MAX_WW-1:0] w);
    return (w == '0) ? MAX_WW'(1) : w;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: circular priority picker starting at ptr, via double-width masked encode
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  localparam int W2 = 2 * N;
  logic [W2-1:0] dbl;
  always_comb begin
    dbl = {req, req} & ~((W2'(1) << ptr) - W2'(1));
    found = |req;
    idx = '0;
    for (int i = W2 - 1; i >= 0; i--) if (dbl[i]) idx = IW'(i % N);
  end
endmodule

// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: N-way round-robin arbiter with per-requester burst credits
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int WW = DEF_WW,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);
  state_t st;
  logic hold, found;
  logic [IW-1:0] pick, owner, ptr, owner_n, ptr_n, idx_n;
  logic [WW-1:0] credit, credit_n, wsel;
  logic [N-1:0] grant_n;
  rr_pick #(.N(N), .IW(IW)) u_pick (.req(req), .ptr(ptr), .found(found), .idx(pick));
  always_comb begin
    st = (grant != '0) ? BUSY : IDLE;
    wsel = weight[pick*WW +: WW];
    hold = (st == BUSY) && req[owner] && (credit > WW'(1));
    grant_n = hold ? grant : found ? N'(onehot(32'(pick), N)) : '0;
    owner_n = (!hold && found) ? pick : owner;
    idx_n = (!hold && found) ? pick : grant_idx;
    ptr_n = (!hold && found) ? ((pick == IW'(N - 1)) ? '0 : pick + IW'(1)) : ptr;
    credit_n = hold ? credit - WW'(1) : found ? WW'(clamp_weight(MAX_WW'(wsel))) : credit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      owner <= '0;
      grant_idx <= '0;
      ptr <= '0;
      credit <= '0;
    end else begin
      grant <= grant_n;
      owner <= owner_n;
      grant_idx <= idx_n;
      ptr <= ptr_n;
      credit <= credit_n;
    end
  end
  assign grant_valid = |grant;
endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
Parametrised N-way weighted round-robin arbiter with per-requester burst credits. A granted requester keeps the grant for up to weight[i] consecutive cycles while it keeps requesting. The grant then rotates to the next requester in circular order. It is the drop-in successor to the fixed 4-way round-robin arbiter for shared-bus and shared-port access, and its grant is registered.

Parameters:
N, 4, number of requesters (N >= 2)
WW, 4, width of each per-requester weight field
IW, $clog2(N), width of grant_idx (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  N  request vector, bit i = requester i
weight  input  N*WW  packed weights; weight[i*WW +: WW] belongs to requester i; value 0 is treated as 1
grant  output  N  one-hot registered grant, all-zero when idle
grant_valid  output  1  high when grant is non-zero
grant_idx  output  IW  index of the current owner; holds its last value when idle

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- State registers: grant, owner (IW bits), credit (WW bits), ptr (IW bits; search start position).
- Reset values: grant=0, grant_valid=0, grant_idx=0, owner=0, credit=0, ptr=0. Reset asserted mid-burst clears the grant immediately, without waiting for a clock edge.
- Latency: grant reflects req sampled at the previous rising edge (1 cycle). No combinational path from req to grant.
- Two states, derived from grant: IDLE (grant==0) and BUSY (grant!=0).
- Hold rule, BUSY: if req[owner]=1 and credit>1, then grant is held and credit decrements by 1.
- Re-arbitration happens in every other case: IDLE, owner dropped req, or credit<=1.
  - The search visits ptr, ptr+1, ..., N-1, 0, ..., ptr-1 and picks the first index with req=1.
  - The current owner is eligible only if it still requests; because ptr=owner+1, it is visited last.
- On a pick i:
  - grant<=onehot(i), owner<=i, grant_idx<=i.
  - credit<=max(weight[i],1), sampled at grant time only; later weight changes do not alter a running burst.
  - ptr<=(i+1) mod N.
- No request in the cycle: grant<=0 and grant_valid<=0. ptr, owner and grant_idx are unchanged.
- Sole requester whose credit expires: it is re-granted back-to-back with a fresh credit load and no idle cycle.
- Owner drops req mid-burst: re-arbitration happens at the next edge and the remaining credit is discarded.
- The ptr wrap from N-1 to 0 must be correct for N not a power of two (e.g. N=3, N=5).
- Max burst length is 2^WW-1 cycles.
- grant is always one-hot or zero; a multi-hot value is a bug.

Decomposition:
- Package arb_pkg:
  - function onehot(idx, N);
  - function clamp_weight(w), which maps 0 to 1;
  - localparam constants for default N and WW.
- Sub-module rr_pick: combinational circular priority picker.
  - Inputs: req[N], ptr[IW].
  - Outputs: found, idx[IW].
  - Implementation: double-width masked priority encode.
  - Verified standalone.
- Top level contains only the credit/owner/ptr registers and the hold/re-arbitrate decision.

Test Plan:
1. N=4, rst=1 with req=1111 for 3 cycles, then rst=0: grant=0000 during reset; 0001 at the first edge after release, then 0010, 0100, 1000, 0001 (all weights 1).
2. weights {w3..w0}={1,1,1,3}, req=0011 held: grant sequence 0001,0001,0001,0010,0001,0001,0001,0010; grant_idx tracks 0,0,0,1,...
3. weight0=4, req=0101: grant=0001 for 2 cycles, then req[0] drops to 0: the next grant is 0100 with no idle cycle; the unused credit is lost.
4. Single requester req=1000, weight3=2 for 6 cycles: grant=1000 and grant_valid=1 continuously. Then req=0000: grant=0000, grant_valid=0, grant_idx stays 3.
5. weight1=0, req=0010 then req=0110: a zero weight behaves as 1, so grant alternates 0010,0100,0010,0100.
6. Reset mid-burst (weight0=5, grant=0001, credit=3), rst pulsed between edges: grant goes to 0 asynchronously. After release with req=1110, the first grant is 0010 (ptr=0, req[0]=0), confirming the ptr reset. Repeat with N=3 to check ptr wrap 2->0.
